// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared opcodes, format codes and payload type for imm_gen_pipe
//
// Purpose: opcode constants, the format-code enum and the payload struct that
// travels through the skid buffer. Payload fields are sized for the widest
// supported datapath (64 bits); narrower configurations use the low bits.
// Ports: none (package).
package imm_gen_pkg;

  localparam int MAX_W = 64;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_OP_32    = 7'b0111011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_Z    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [MAX_W-1:0] imm;
    fmt_e             fmt;
    logic             illegal;
    logic [MAX_W-1:0] target;
    logic [MAX_W-1:0] pc;
  } payload_t;

  function automatic logic [MAX_W-1:0] sext32(input logic [31:0] v);
    return {{(MAX_W-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// rtl/imm_skid_buf.sv - generic 2-entry valid/ready skid buffer
//
// Purpose: registered pipeline stage with a main register driving the outputs
// and a skid register catching one beat under backpressure. in_ready is a
// register (the inverse of skid occupancy), so upstream never sees a
// combinational path from out_ready.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   flush             drops both held beats and any beat offered this cycle
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
module imm_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         in_ready_q, in_ready_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         in_fire, out_fire;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!main_valid_q || out_fire) begin
      // Main is free next cycle: the older skid beat has priority; in_ready is
      // low whenever skid is full, so no new beat can arrive at the same time.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_fire;
        if (in_fire) begin
          main_data_d = in_data;
        end
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RISC-V immediate generator with PC-relative target
//
// Purpose: decodes one instruction per valid/ready beat into immediate, format
// code, illegal-opcode flag and pc+imm target, registered behind a 2-entry
// skid buffer (1 cycle latency, full throughput). XLEN is 32 or 64; PC_W <= 64.
// Optional feature macro: IMM_CSR_ZIMM_EN - CSR*I instructions report fmt Z
// with the zero-extended 5-bit zimm; without it SYSTEM is always fmt NONE.
// Ports:
//   clk, reset, flush               clock, sync active-high reset, pipeline flush
//   in_valid/in_ready               upstream handshake
//   in_instr, in_pc                 instruction word and its address
//   out_valid/out_ready             downstream handshake
//   out_imm, out_fmt, out_illegal   decoded immediate, format code, bad opcode
//   out_target, out_pc              pc+imm (B, J, AUIPC; else 0), pc pass-through
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_target,
  output logic [PC_W-1:0] out_pc
);

  logic [6:0]       opcode;
  fmt_e             dec_fmt;
  logic             dec_illegal;
  logic             dec_tgt_en;
  logic [31:0]      dec_imm32;
  logic [MAX_W-1:0] dec_imm64;
  logic [PC_W-1:0]  dec_tgt;
  payload_t         dec_pl;
  payload_t         buf_pl;

  assign opcode = in_instr[6:0];

  // Every immediate fits a signed 32-bit value; wider datapaths sign-extend it,
  // which also gives RV64 LUI/AUIPC their bit-31 extension.
  always_comb begin
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    dec_tgt_en  = 1'b0;
    dec_imm32   = '0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_IMM_32: begin
        if (XLEN == 64) begin
          dec_fmt   = FMT_I;
          dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_STORE: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        dec_fmt    = FMT_B;
        dec_tgt_en = 1'b1;
        dec_imm32  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_LUI: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {in_instr[31:12], 12'b0};
      end
      OP_AUIPC: begin
        dec_fmt    = FMT_U;
        dec_tgt_en = 1'b1;
        dec_imm32  = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        dec_fmt    = FMT_J;
        dec_tgt_en = 1'b1;
        dec_imm32  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      end
      OP_OP, OP_MISC_MEM: begin
      end
      OP_SYSTEM: begin
`ifdef IMM_CSR_ZIMM_EN
        // funct3[2] selects the immediate CSR forms; rs1 field carries zimm.
        if (in_instr[14]) begin
          dec_fmt   = FMT_Z;
          dec_imm32 = {27'b0, in_instr[19:15]};
        end
`else
`endif
      end
      OP_OP_32: begin
        if (XLEN != 64) begin
          dec_illegal = 1'b1;
        end
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign dec_imm64 = sext32(dec_imm32);
  // Truncating add: the target wraps modulo 2^PC_W.
  assign dec_tgt   = dec_tgt_en ? (in_pc + dec_imm64[PC_W-1:0]) : '0;

  always_comb begin
    dec_pl.imm     = dec_imm64;
    dec_pl.fmt     = dec_fmt;
    dec_pl.illegal = dec_illegal;
    dec_pl.target  = MAX_W'(dec_tgt);
    dec_pl.pc      = MAX_W'(in_pc);
  end

  imm_skid_buf #(
    .W($bits(payload_t))
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (dec_pl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (buf_pl)
  );

  assign out_imm     = buf_pl.imm[XLEN-1:0];
  assign out_fmt     = buf_pl.fmt;
  assign out_illegal = buf_pl.illegal;
  assign out_target  = buf_pl.target[PC_W-1:0];
  assign out_pc      = buf_pl.pc[PC_W-1:0];

  // Upper payload bits beyond XLEN/PC_W are carried but not presented.
  logic unused_pl_bits;
  assign unused_pl_bits = ^{buf_pl.imm, buf_pl.target, buf_pl.pc};

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench for imm_gen_pipe (RV32 and RV64 instances)
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_target32, out_pc32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64, out_target64, out_pc64;
  logic [2:0]  out_fmt64;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32),
    .out_target(out_target32), .out_pc(out_pc32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64),
    .out_target(out_target64), .out_pc(out_pc64)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] tgt;
    logic [63:0] pc;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t cur32, cur64;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] imm, input logic [2:0] fmt, input logic ill,
                              input logic [63:0] tgt, input logic [63:0] pc);
    exp_t e;
    e.imm = imm; e.fmt = fmt; e.ill = ill; e.tgt = tgt; e.pc = pc;
    return e;
  endfunction

  // Reference decoder, built at 64 bits and narrowed for RV32.
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc, input bit rv64);
    exp_t        e;
    logic [63:0] mask;
    bit          tgt_en;
    e.imm = 64'd0; e.fmt = 3'd7; e.ill = 1'b0; tgt_en = 1'b0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: begin e.fmt = 3'd0; e.imm = {{52{ins[31]}}, ins[31:20]}; end
      7'h1B: if (rv64) begin e.fmt = 3'd0; e.imm = {{52{ins[31]}}, ins[31:20]}; end
             else e.ill = 1'b1;
      7'h23: begin e.fmt = 3'd1; e.imm = {{52{ins[31]}}, ins[31:25], ins[11:7]}; end
      7'h63: begin
        e.fmt = 3'd2; tgt_en = 1'b1;
        e.imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'h37: begin e.fmt = 3'd3; e.imm = {{32{ins[31]}}, ins[31:12], 12'b0}; end
      7'h17: begin e.fmt = 3'd3; tgt_en = 1'b1; e.imm = {{32{ins[31]}}, ins[31:12], 12'b0}; end
      7'h6F: begin
        e.fmt = 3'd4; tgt_en = 1'b1;
        e.imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'h33, 7'h0F: ;
      7'h73: begin
`ifdef IMM_CSR_ZIMM_EN
        if (ins[14]) begin e.fmt = 3'd5; e.imm = {59'd0, ins[19:15]}; end
`endif
      end
      7'h3B: if (!rv64) e.ill = 1'b1;
      default: e.ill = 1'b1;
    endcase
    e.tgt = tgt_en ? pc + e.imm : 64'd0;
    e.pc  = pc;
    mask  = rv64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    e.imm = e.imm & mask;
    e.tgt = e.tgt & mask;
    e.pc  = e.pc & mask;
    return e;
  endfunction

  // Handshakes are observed mid-cycle; inputs only change just after posedge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q32.delete();
      q64.delete();
    end else begin
      if (out_valid32 && out_ready) begin
        check_eq("q32_nonempty", q32.size() != 0, 1);
        if (q32.size() != 0) begin
          e = q32.pop_front();
          check_eq("imm32", out_imm32, e.imm);
          check_eq("fmt32", out_fmt32, e.fmt);
          check_eq("ill32", out_illegal32, e.ill);
          check_eq("tgt32", out_target32, e.tgt);
          check_eq("pc32", out_pc32, e.pc);
        end
      end
      if (out_valid64 && out_ready) begin
        check_eq("q64_nonempty", q64.size() != 0, 1);
        if (q64.size() != 0) begin
          e = q64.pop_front();
          check_eq("imm64", out_imm64, e.imm);
          check_eq("fmt64", out_fmt64, e.fmt);
          check_eq("ill64", out_illegal64, e.ill);
          check_eq("tgt64", out_target64, e.tgt);
          check_eq("pc64", out_pc64, e.pc);
        end
      end
      if (flush) begin
        q32.delete();
        q64.delete();
      end else begin
        if (in_valid && in_ready32) q32.push_back(cur32);
        if (in_valid && in_ready64) q64.push_back(cur64);
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [63:0] pc, input exp_t e32, input exp_t e64);
    int n = 0;
    in_instr = ins;
    in_pc    = pc;
    cur32    = e32;
    cur64    = e64;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready32 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check_eq("send_timeout", in_ready32, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [31:0] ins, input logic [63:0] pc);
    send(ins, pc, model(ins, pc, 1'b0), model(ins, pc, 1'b1));
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((q32.size() != 0 || q64.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain32", q32.size(), 0);
    check_eq("drain64", q64.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  bit done;

  initial begin
    logic [31:0] tmp;
    logic [6:0]  ops[16];
    ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17,
            7'h6F, 7'h33, 7'h0F, 7'h73, 7'h3B, 7'h7F, 7'h12, 7'h5B};
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 64'd0;
    cur32 = mk(0, 0, 0, 0, 0); cur64 = cur32;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready32", in_ready32, 0);
    check_eq("rst_in_ready64", in_ready64, 0);
    check_eq("rst_out_valid32", out_valid32, 0);
    check_eq("rst_out_imm32", out_imm32, 0);
    check_eq("rst_out_fmt32", out_fmt32, 0);
    check_eq("rst_out_ill32", out_illegal32, 0);
    check_eq("rst_out_tgt64", out_target64, 0);
    check_eq("rst_out_pc64", out_pc64, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_in_ready32", in_ready32, 1);
    check_eq("post_rst_in_ready64", in_ready64, 1);

    // First beat: latency of one cycle from accept
    send(32'hFE000CE3, 64'h100, mk(64'hFFFFFFF8, 3'd2, 0, 64'hF8, 64'h100),
         mk(64'hFFFFFFFFFFFFFFF8, 3'd2, 0, 64'hF8, 64'h100));
    check_eq("lat_out_valid32", out_valid32, 1);
    check_eq("lat_out_valid64", out_valid64, 1);
    out_ready = 1'b1;

    // Directed vectors, back to back
    send(32'h001000EF, 64'h1000, mk(64'h800, 3'd4, 0, 64'h1800, 64'h1000),
         mk(64'h800, 3'd4, 0, 64'h1800, 64'h1000));
    send(32'hFE21AE23, 64'h2000, mk(64'hFFFFFFFC, 3'd1, 0, 0, 64'h2000),
         mk(64'hFFFFFFFFFFFFFFFC, 3'd1, 0, 0, 64'h2000));
    send(32'h800002B7, 64'h3000, mk(64'h80000000, 3'd3, 0, 0, 64'h3000),
         mk(64'hFFFFFFFF80000000, 3'd3, 0, 0, 64'h3000));
    send(32'h00000000, 64'h4000, mk(0, 3'd7, 1, 0, 64'h4000), mk(0, 3'd7, 1, 0, 64'h4000));
`ifdef IMM_CSR_ZIMM_EN
    send(32'h340FD073, 64'h5000, mk(64'h1F, 3'd5, 0, 0, 64'h5000), mk(64'h1F, 3'd5, 0, 0, 64'h5000));
`else
    send(32'h340FD073, 64'h5000, mk(0, 3'd7, 0, 0, 64'h5000), mk(0, 3'd7, 0, 0, 64'h5000));
`endif
    send(32'h00001097, 64'h200, mk(64'h1000, 3'd3, 0, 64'h1200, 64'h200),
         mk(64'h1000, 3'd3, 0, 64'h1200, 64'h200));
    send(32'hFFF0809B, 64'h300, mk(0, 3'd7, 1, 0, 64'h300),
         mk(64'hFFFFFFFFFFFFFFFF, 3'd0, 0, 0, 64'h300));
    send(32'hFFDFF06F, 64'h0, mk(64'hFFFFFFFC, 3'd4, 0, 64'hFFFFFFFC, 0),
         mk(64'hFFFFFFFFFFFFFFFC, 3'd4, 0, 64'hFFFFFFFFFFFFFFFC, 0));
    send(32'h00000033, 64'h10, mk(0, 3'd7, 0, 0, 64'h10), mk(0, 3'd7, 0, 0, 64'h10));
    send(32'h00000012, 64'h20, mk(0, 3'd7, 1, 0, 64'h20), mk(0, 3'd7, 1, 0, 64'h20));
    send(32'h0000003B, 64'h30, mk(0, 3'd7, 1, 0, 64'h30), mk(0, 3'd7, 0, 0, 64'h30));
    drain();

    // Backpressure: out_ready low for three cycles while beats keep coming
    out_ready = 1'b0;
    send_model(32'h00A00093, 64'h400);
    check_eq("bp_ready_after1", in_ready32, 1);
    send_model(32'hFE0008E3, 64'h404);
    check_eq("bp_ready_after2_32", in_ready32, 0);
    check_eq("bp_ready_after2_64", in_ready64, 0);
    in_instr = 32'h123452B7; in_pc = 64'h408;
    cur32 = model(in_instr, in_pc, 1'b0); cur64 = model(in_instr, in_pc, 1'b1);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_ready_held", in_ready32, 0);
    check_eq("bp_out_valid_held", out_valid32, 1);
    out_ready = 1'b1;
    send_model(32'h123452B7, 64'h408);
    send_model(32'h0080006F, 64'h40C);
    drain();

    // Flush with main and skid both occupied
    out_ready = 1'b0;
    send_model(32'h00100093, 64'h500);
    send_model(32'h00200093, 64'h504);
    check_eq("fl_ready_full", in_ready32, 0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00300093;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check_eq("fl_out_valid32", out_valid32, 0);
    check_eq("fl_out_valid64", out_valid64, 0);
    check_eq("fl_in_ready32", in_ready32, 1);

    // Flush drops a beat offered in the same cycle
    send_model(32'h00400093, 64'h600);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 64'h604;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check_eq("fl2_out_valid", out_valid32, 0);
    check_eq("fl2_in_ready", in_ready32, 1);
    @(posedge clk);
    #1;
    check_eq("fl2_out_valid_later", out_valid64, 0);

    // Reset while beats are held: nothing is replayed
    send_model(32'h00600093, 64'h700);
    send_model(32'h00700093, 64'h704);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_in_ready", in_ready32, 0);
    check_eq("mid_rst_out_valid", out_valid32, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_ready_after", in_ready64, 1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_rst_no_replay32", out_valid32, 0);
    check_eq("mid_rst_no_replay64", out_valid64, 0);

    // Random traffic with random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          tmp = $urandom();
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_model({tmp[31:7], ops[$urandom_range(0, 15)]}, {$urandom(), $urandom()});
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    @(posedge clk);
    #1;
    check_eq("final_out_valid", out_valid32, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate generator. It sits between fetch and decode/execute and takes one instruction plus its PC per valid/ready beat. Per beat it produces the sign/zero-extended immediate, a format code, an illegal-opcode flag and a PC-relative target (pc + imm).
- Width is XLEN-generic (RV32/RV64).
- Output is registered behind a 2-entry skid buffer, giving full throughput under backpressure.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
PC_W, XLEN, width of pc input and target output

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous pipeline flush; drops all held beats
in_valid  in  1  upstream beat valid
in_ready  out  1  block can accept a beat this cycle
in_instr  in  32  instruction word
in_pc  in  PC_W  instruction address
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_imm  out  XLEN  generated immediate
out_fmt  out  3  format code (package enum)
out_illegal  out  1  unrecognised opcode
out_target  out  PC_W  pc + imm for B, J and AUIPC formats; 0 otherwise
out_pc  out  PC_W  pc pass-through

Behaviour:
- Reset: all outputs 0, both buffer entries invalid, in_ready=0 while reset is high, in_ready=1 the cycle after. Reset has priority over flush.
- Decode, combinational on input, by opcode[6:0]:
  - I-format: 0010011, 0000011, 1100111. In RV64 also 0011011. imm = sext(instr[31:20]).
  - S-format: 0100011. imm = sext({instr[31:25], instr[11:7]}).
  - B-format: 1100011. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U-format: 0110111, 0010111. imm = sext({instr[31:12], 12'b0}) to XLEN; RV64 sign-extends bit 31.
  - J-format: 1101111. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - NONE: 0110011, 0001111, 1110011; in RV64 also 0111011. imm=0, illegal=0.
  - Any other opcode, including opcode[1:0]!=2'b11: fmt=NONE, imm=0, illegal=1.
- Target: computed in the same stage, pc + imm truncated to PC_W, wraps modulo 2^PC_W with no overflow flag. target=0 for I/S/NONE and for LUI.
- Latency: 1 cycle from accepted input to out_valid.
- Handshake:
  - Transfer occurs when valid&&ready on each side.
  - out_valid holds and payload stays stable until accepted.
  - in_ready is registered: in_ready = !skid_valid.
- Skid buffer: main register feeds the outputs.
  - If main holds an unaccepted beat and a new beat arrives, the new beat goes to skid.
  - When main drains, skid moves to main and skid clears.
  - Simultaneous accept-out and accept-in with skid empty: main reloads directly, throughput 1/cycle.
  - Order is always preserved; no beat is duplicated or lost.
- Flush: next cycle out_valid=0 and skid invalid. A beat presented with in_valid in the flush cycle is dropped. in_ready=1 the cycle after flush.
- Reset mid-transfer: held beats are discarded and not replayed.

Optional Feature:
IMM_CSR_ZIMM_EN.
- Defined: opcode 1110011 with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) gives fmt=Z, imm = zext(instr[19:15]), target=0.
- Undefined: SYSTEM is always fmt=NONE, imm=0; fmt code Z never appears.

Decomposition:
- Package imm_gen_pkg holds:
  - opcode localparams;
  - fmt enum: I=0, S=1, B=2, U=3, J=4, Z=5, NONE=7;
  - a payload struct {imm, fmt, illegal, target, pc}.
- Sub-module imm_skid_buf: generic 2-entry valid/ready skid buffer, payload-width parameter.
- Decode/add logic stays in the top module.

Test Plan:
- XLEN=32: beq 0xFE000CE3, pc=0x100 -> imm=0xFFFFFFF8, fmt=B, target=0x000000F8, out_valid one cycle after accept.
- jal 0x001000EF, pc=0x1000 -> imm=0x00000800, fmt=J, target=0x1800.
- sw 0xFE21AE23 -> imm=0xFFFFFFFC, fmt=S, target=0.
- XLEN=64: lui 0x800002B7 -> imm=0xFFFFFFFF80000000, fmt=U, target=0.
- Instr 0x00000000 -> illegal=1, fmt=NONE, imm=0.
- Backpressure: 4 back-to-back beats with out_ready=0 for 3 cycles -> in_ready=0 after 2 accepted; beats emerge in order with no loss. Then flush with 2 held -> out_valid=0 next cycle, in_ready=1.
- IMM_CSR_ZIMM_EN: csrrwi 0x340FD073 -> imm=0x1F, fmt=Z. Without macro -> imm=0, fmt=NONE.
